// File: rtl/vga_sprite_engine.sv
// VGA raster generator with NUM_OBJ bus-programmable rectangles composited over a border and background.
// Object registers are double-buffered and committed on the last active pixel of each frame.
module vga_sprite_engine #(
   parameter int          NUM_OBJ      = 4,
   parameter int          H_ACTIVE     = 640,
   parameter int          H_FP         = 16,
   parameter int          H_SYNC       = 96,
   parameter int          H_BP         = 48,
   parameter int          V_ACTIVE     = 480,
   parameter int          V_FP         = 10,
   parameter int          V_SYNC       = 2,
   parameter int          V_BP         = 33,
   parameter int          BORDER_W     = 10,
   parameter logic [7:0]  BORDER_COLOR = 8'h6D,
   parameter logic [7:0]  BG_COLOR     = 8'h00,
   localparam int         ADDR_W       = $clog2(NUM_OBJ) + 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [9:0]        data_in,
   output logic              HS,
   output logic              VS,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [1:0]        blue,
   output logic              vblank,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] w;
      logic [9:0] h;
      logic [7:0] color;
      logic       en;
   } obj_t;

   logic [HW-1:0] h;
   logic [VW-1:0] v;
   int            hi;
   int            vi;
   obj_t          stg  [NUM_OBJ];
   obj_t          live [NUM_OBJ];
   logic [7:0]    pix;
   logic          commit;
   logic          wr_ok;

   assign hi     = int'(h);
   assign vi     = int'(v);
   assign commit = (hi == H_ACTIVE - 1) && (vi == V_ACTIVE - 1);
   assign wr_ok  = sel && (int'(addr >> 3) < NUM_OBJ);

   always_ff @(posedge clk) begin
      if (!rst) begin
         h <= '0;
         v <= '0;
      end else if (hi == H_TOTAL - 1) begin
         h <= '0;
         v <= (vi == V_TOTAL - 1) ? '0 : v + VW'(1);
      end else begin
         h <= h + HW'(1);
      end
   end

   // NOTE: the object tables are flops, not RAM, so reset can clear every entry and leave all objects disabled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            stg[i]  <= '0;
            live[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignment makes the commit copy the pre-write staging value when both land in one cycle.
         if (commit) live <= stg;
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (wr_ok && int'(addr >> 3) == i) begin
               case (addr[2:0])
                  3'd0:    stg[i].x     <= data_in;
                  3'd1:    stg[i].y     <= data_in;
                  3'd2:    stg[i].w     <= data_in;
                  3'd3:    stg[i].h     <= data_in;
                  3'd4:    stg[i].color <= data_in[7:0];
                  3'd5:    stg[i].en    <= data_in[0];
                  default: ;
               endcase
            end
         end
      end
   end

   // Walking from the highest index down lets the lowest-index hit overwrite all others.
   always_comb begin
      logic [10:0] x_end;
      logic [10:0] y_end;
      x_end = '0;
      y_end = '0;
      pix   = BG_COLOR;
      if (hi < BORDER_W || hi >= H_ACTIVE - BORDER_W || vi < BORDER_W || vi >= V_ACTIVE - BORDER_W)
         pix = BORDER_COLOR;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
         x_end = {1'b0, live[i].x} + {1'b0, live[i].w};
         y_end = {1'b0, live[i].y} + {1'b0, live[i].h};
         if (live[i].en && hi >= int'(live[i].x) && hi < int'(x_end) &&
             vi >= int'(live[i].y) && vi < int'(y_end))
            pix = live[i].color;
      end
      if (!(hi < H_ACTIVE && vi < V_ACTIVE)) pix = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         HS                 <= 1'b1;
         VS                 <= 1'b1;
         {red, green, blue} <= '0;
         vblank             <= 1'b0;
         frame_start        <= 1'b0;
      end else begin
         HS                 <= !(hi >= H_ACTIVE + H_FP && hi < H_ACTIVE + H_FP + H_SYNC);
         VS                 <= !(vi >= V_ACTIVE + V_FP && vi < V_ACTIVE + V_FP + V_SYNC);
         {red, green, blue} <= pix;
         vblank             <= (vi >= V_ACTIVE);
         frame_start        <= (hi == 0) && (vi == 0);
      end
   end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine on a reduced raster: every pin is compared each cycle
// against a pixel-rule model, plus directed checks of timing, priority, commit and reset behaviour.
module tb_vga_sprite_engine;

   localparam int NUM = 3;
   localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
   localparam int VA = 40, VF = 2, VSY = 2, VB = 3;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int BW = 4;
   localparam int AW = $clog2(NUM) + 3;
   localparam logic [7:0] BORD = 8'h6D;
   localparam logic [7:0] BG   = 8'h25;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sel = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [9:0]    data_in = '0;
   logic          HS, VS, vblank, frame_start;
   logic [2:0]    red, green;
   logic [1:0]    blue;

   vga_sprite_engine #(
      .NUM_OBJ(NUM), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .BORDER_W(BW), .BORDER_COLOR(BORD), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .addr(addr), .data_in(data_in),
      .HS(HS), .VS(VS), .red(red), .green(green), .blue(blue),
      .vblank(vblank), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, w, h, color;
      bit en;
   } obj_t;

   obj_t stg_m  [NUM];
   obj_t live_m [NUM];
   int   mh, mv, last_h, last_v;
   int   n_checks = 0, n_fail = 0;
   int   fs_cnt, hs_low, vs_low;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pins for raster position (hh,vv): {HS,VS,vblank,frame_start,rgb332}.
   function automatic logic [11:0] model_pins(input int hh, input int vv);
      int c;
      bit hs, vs;
      c = BG;
      if (hh < BW || hh >= HA - BW || vv < BW || vv >= VA - BW) c = BORD;
      for (int i = 0; i < NUM; i++) begin
         if (live_m[i].en && live_m[i].x <= hh && hh < live_m[i].x + live_m[i].w &&
             live_m[i].y <= vv && vv < live_m[i].y + live_m[i].h) begin
            c = live_m[i].color;
            break;
         end
      end
      if (!(hh < HA && vv < VA)) c = 0;
      hs = !(hh >= HA + HF && hh < HA + HF + HSY);
      vs = !(vv >= VA + VF && vv < VA + VF + VSY);
      return {hs, vs, (vv >= VA), (hh == 0 && vv == 0), c[7:0]};
   endfunction

   task automatic model_write(input int a, input int d);
      int o, k;
      o = a >> 3;
      k = a & 7;
      if (o < NUM) begin
         case (k)
            0: stg_m[o].x     = d;
            1: stg_m[o].y     = d;
            2: stg_m[o].w     = d;
            3: stg_m[o].h     = d;
            4: stg_m[o].color = d & 255;
            5: stg_m[o].en    = d[0];
            default: ;
         endcase
      end
   endtask

   task automatic tick(input bit s = 0, input int a = 0, input int d = 0);
      logic [11:0] exp;
      sel     = s;
      addr    = AW'(a);
      data_in = 10'(d);
      @(posedge clk);
      if (!rst) begin
         exp = 12'hC00;
         for (int i = 0; i < NUM; i++) begin
            stg_m[i]  = '{default: 0};
            live_m[i] = '{default: 0};
         end
         mh = 0; mv = 0; last_h = -1; last_v = -1;
      end else begin
         exp = model_pins(mh, mv);
         if (mh == HA - 1 && mv == VA - 1) live_m = stg_m;
         if (s) model_write(a, d);
         last_h = mh; last_v = mv;
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
         end
      end
      #1;
      check($sformatf("pins(%0d,%0d)", last_h, last_v),
            {20'd0, HS, VS, vblank, frame_start, red, green, blue}, {20'd0, exp});
      if (frame_start) fs_cnt++;
      if (!HS) hs_low++;
      if (!VS) vs_low++;
   endtask

   task automatic wr(input int obj, input int k, input int d);
      tick(1'b1, obj * 8 + k, d);
   endtask

   task automatic wr_obj(input int obj, input int x, input int y, input int w, input int h,
                         input int c, input int en);
      wr(obj, 0, x); wr(obj, 1, y); wr(obj, 2, w); wr(obj, 3, h); wr(obj, 4, c); wr(obj, 5, en);
   endtask

   task automatic run_to(input int th, input int tv);
      bit hit = 0;
      for (int n = 0; n < HT * VT + 2 && !hit; n++) begin
         tick();
         hit = (last_h == th && last_v == tv);
      end
      check($sformatf("reach(%0d,%0d)", th, tv), {31'd0, hit}, 32'd1);
   endtask

   task automatic px(input string tag, input int th, input int tv, input logic [7:0] c);
      run_to(th, tv);
      check(tag, {24'd0, red, green, blue}, {24'd0, c});
   endtask

   initial begin
      // Reset values held while rst is low.
      rst = 1'b0;
      repeat (3) tick();
      check("rst_hs", {31'd0, HS}, 32'd1);

      // Release: pixel (0,0) on the pins with frame_start and border colour.
      rst = 1'b1;
      fs_cnt = 0; hs_low = 0; vs_low = 0;
      tick();
      check("origin_fs", {31'd0, frame_start}, 32'd1);
      check("origin_rgb", {24'd0, red, green, blue}, {24'd0, BORD});
      repeat (2 * HT * VT - 1) tick();
      check("fs_per_2frames", fs_cnt, 32'd2);
      check("hs_low_cycles", hs_low, 2 * VT * HSY);
      check("vs_low_cycles", vs_low, 2 * VSY * HT);
      px("blank_rgb_zero", HA + 1, 5, 8'h00);

      // Single red object, visible after one commit.
      wr_obj(0, 20, 10, 10, 10, 8'hC0, 1);
      run_to(HA - 1, VA - 1);
      px("obj0_left_outside", 19, 10, BG);
      px("obj0_first", 20, 10, 8'hC0);
      check("obj0_red", {29'd0, red}, 32'd6);
      check("obj0_green", {29'd0, green}, 32'd0);
      check("obj0_blue", {30'd0, blue}, 32'd0);
      px("obj0_right_edge", 29, 10, 8'hC0);
      px("obj0_right_outside", 30, 10, BG);
      px("obj0_last", 29, 19, 8'hC0);
      px("obj0_below", 20, 20, BG);

      // Overlap: lower index wins.
      wr_obj(1, 20, 10, 10, 10, 8'h1C, 1);
      run_to(HA - 1, VA - 1);
      px("overlap_obj0_wins", 25, 15, 8'hC0);

      // Write obj0 X on the exact commit cycle.
      wr(1, 5, 0);
      run_to(HA - 2, VA - 1);
      wr(0, 0, 40);
      px("commit_old_x_shown", 20, 10, 8'hC0);
      px("commit_new_x_absent", 40, 10, BG);
      run_to(HA - 1, VA - 1);
      px("next_old_x_gone", 20, 10, BG);
      px("next_new_x_shown", 40, 10, 8'hC0);

      // Clipping at the right edge and a zero-width object.
      wr_obj(2, 60, 20, 20, 5, 8'h03, 1);
      wr_obj(1, 30, 30, 0, 5, 8'hE0, 1);
      run_to(HA - 1, VA - 1);
      px("clip_before", 59, 20, BG);
      px("clip_first", 60, 20, 8'h03);
      px("clip_last", 63, 20, 8'h03);
      px("clip_no_wrap_border", 2, 21, BORD);
      px("clip_no_wrap_bg", 10, 21, BG);
      px("zero_width", 30, 30, BG);

      // Randomised bus traffic, each pixel checked against the model.
      repeat (150) begin
         tick(1'b1, $urandom_range(0, (1 << AW) - 1),
              ($urandom % 2) ? $urandom_range(0, 63) : $urandom_range(0, 1023));
         repeat ($urandom_range(0, 120)) tick();
      end
      repeat (2 * HT * VT) tick();

      // Mid-frame reset clears objects and restarts the raster.
      wr_obj(0, 20, 10, 10, 10, 8'hC0, 1);
      run_to(HA - 1, VA - 1);
      px("pre_reset_obj", 20, 10, 8'hC0);
      run_to(33, 12);
      rst = 1'b0;
      tick();
      check("midrst_rgb", {24'd0, red, green, blue}, 32'd0);
      check("midrst_sync", {30'd0, HS, VS}, 32'd3);
      check("midrst_fs", {31'd0, frame_start}, 32'd0);
      rst = 1'b1;
      tick();
      check("restart_fs", {31'd0, frame_start}, 32'd1);
      check("restart_rgb", {24'd0, red, green, blue}, {24'd0, BORD});
      px("restart_obj_disabled", 20, 10, BG);
      run_to(HA - 1, VA - 1);
      px("restart_still_disabled", 20, 10, BG);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sprite_engine.md
# vga_sprite_engine

Parametrised successor to the fixed Pong display. It integrates its own raster timing generator, composites `NUM_OBJ` bus-programmable rectangular objects over a border and background, and drives the VGA pins. Object geometry and colour are written from the CPU data bus into staging registers. Staging is committed to live registers only at end of frame, so updates never tear.

## Interface
Parameters:
- `NUM_OBJ`, 4: number of objects (1..16).
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing in pixel clocks.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing in lines.
- `BORDER_W`, 10: border thickness in pixels; 0 disables the border.
- `BORDER_COLOR`, 8'h6D: RGB332 colour of the border.
- `BG_COLOR`, 8'h00: RGB332 colour of the background.
- `ADDR_W`, derived: clog2(`NUM_OBJ`)+3.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: synchronous, active-low reset.
- `sel`, in, 1: bus write strobe, one write per cycle.
- `addr`, in, `ADDR_W`: register index; obj = addr[ADDR_W-1:3], k = addr[2:0].
- `data_in`, in, 10: write data.
- `HS`, out, 1: horizontal sync, active-low.
- `VS`, out, 1: vertical sync, active-low.
- `red`, out, 3: red pixel component.
- `green`, out, 3: green pixel component.
- `blue`, out, 2: blue pixel component.
- `vblank`, out, 1: high while the current line is at or beyond `V_ACTIVE`.
- `frame_start`, out, 1: one-cycle pulse, registered, aligned with pixel (0,0) on the pins.

## Operation
- Register map per object (k):
  - 0: X[9:0].
  - 1: Y[9:0].
  - 2: W[9:0].
  - 3: H[9:0].
  - 4: COLOR[7:0] as {r[2:0], g[2:0], b[1:0]}.
  - 5: CTRL, bit0 = enable.
  - 6 and 7: reserved; writes are ignored.
- Writes with obj ≥ `NUM_OBJ` are ignored.
- Writes land in staging registers. Live registers copy all staging registers on the commit cycle: h == H_ACTIVE-1 and v == V_ACTIVE-1.
- A write on the commit cycle updates staging only. The committed value is the pre-write staging value; the new value appears one frame later.
- Raster counters:
  - h counts 0..H_TOTAL-1, then wraps to 0 and increments v.
  - v counts 0..V_TOTAL-1, then wraps to 0.
  - H_TOTAL and V_TOTAL are the sums of their four timing parameters.
- Sync windows:
  - HS is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS is low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Object hit test:
  - enable && X ≤ h < X+W && Y ≤ v < Y+H.
  - Sums are 11-bit, so there is no wrap.
  - W=0 or H=0 never hits.
  - Objects extending past the active area are clipped.
- Border hit: h < BORDER_W, or h ≥ H_ACTIVE-BORDER_W, or v < BORDER_W, or v ≥ V_ACTIVE-BORDER_W.
- Priority: lowest-index hit object, then border, then `BG_COLOR`.
- Outside the active area, RGB is forced to 0.
- Reset, including mid-frame:
  - h and v return to 0.
  - All staging and live registers clear, so every object is disabled.
  - Outputs: HS=1, VS=1, red/green/blue=0, vblank=0, frame_start=0.

## Timing
- RGB, HS, VS, vblank and frame_start are all registered with 1-cycle latency from the raster counters, and are mutually aligned.
- First cycle after reset release: counters at (0,0). The pins show pixel (0,0) on the following cycle, with frame_start=1.
- A staging write at cycle t is visible on the pins starting with the first frame whose commit occurs after t.
- The commit falls in the last active pixel, so the whole next frame uses one consistent register set.
- Simultaneous writes to different objects are impossible (one bus). Back-to-back writes on consecutive cycles are all accepted.
- Pipeline throughput: 1 pixel per clock, no stalls.

## Test plan
- Reset release, then run 2 frames → HS period 800 clocks with 96 low; VS period 420000 clocks with 2 lines low; frame_start pulses exactly once per frame; RGB=0 outside active area; border colour 8'h6D at (0,0).
- Write obj0: X=100, Y=50, W=10, H=10, COLOR=8'hC0, enable=1; wait one commit → pixels (100..109, 50..59) are red=6, green=0, blue=0; (110,50) is background.
- Overlap obj0 and obj1 at the same rectangle with different colours → obj0's colour is shown on the pins.
- Write obj0 X=200 on the exact commit cycle → the next frame still shows X=100; the frame after shows X=200.
- Object with X=635, W=20 → visible only at h 635..639; nothing appears at h 0..14 of the next line; W=0 → never visible.
- Assert rst mid-frame for 1 cycle → all outputs take reset values on the next cycle; after release, the frame restarts at (0,0) with all objects disabled.
